serial_subtractor_seq: RTL

// - Bit-serial N-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
// - Upstream sequencer of the single-bit full-subtractor cell: shift registers feed it
//   a/b bits, and a borrow flip-flop closes the loop.
// - Parallel result and borrow-out are returned with a start/done handshake.
// - Area-cheap alternative to a ripple subtractor where latency is acceptable.

---
 rtl/serial_subtractor_seq_pkg.sv | 13 +
 rtl/serial_subtractor_seq_if.sv | 29 ++
 rtl/serial_subtractor_seq_fs_bit_cell.sv | 14 +
 rtl/serial_subtractor_seq.sv | 92 +++++++++
 4 files changed

// File: rtl/serial_subtractor_seq_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
// Pure declarations; no latency or flow-control behaviour of its own.
package serial_subtractor_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_seq_if.sv
// Request/result bundle for the serial subtractor: start + operands in, status + result out.
// Backpressure: start is honoured only while ready is high; nothing is queued.
interface serial_subtractor_seq_if
  import serial_subtractor_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a_in, b_in, bin_in,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, a_in, b_in, bin_in,
    output ready, busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_seq_fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
// Zero latency; no flow control.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor_seq.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first; done pulses WIDTH cycles after accept.
// Backpressure: start is accepted only in IDLE (ready=1); requests while busy/done are dropped.
module serial_subtractor_seq
  import serial_subtractor_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_seq_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_nxt;
  logic             brw;
  logic             bout_r;
  logic             d_bit;
  logic             brw_nxt;

  fs_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (brw_nxt)
  );

  // Result bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_nxt = d_bit;
    end else begin : g_wn
      assign diff_nxt = {d_bit, diff_r[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      brw    <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.b_in;
            brw    <= bus.bin_in;
            cnt    <= '0;
            diff_r <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          brw    <= brw_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          diff_r <= diff_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout_r <= brw_nxt;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = (state == S_SHIFT);
  assign bus.done  = (state == S_DONE);
  assign bus.diff  = diff_r;
  assign bus.bout  = bout_r;

endmodule
